// File: rtl/pci_ad_drive_sequencer.sv
// AD/CBE/PAR pad ownership sequencer: master/target arbitration, turnaround and optional bus parking.
// Bus parking is compiled in when the macro PCI_BUS_PARK_EN is defined.
module pci_ad_drive_sequencer #(
    parameter int unsigned OE_WIDTH          = 32,
    parameter int unsigned TURNAROUND_CYCLES = 1
) (
    input  logic                pci_clk,
    input  logic                pci_reset_l,
    input  logic                pci_gnt_in_prev,
    input  logic                pci_bus_idle_prev,
    input  logic                master_req,
    input  logic                master_done,
    input  logic                target_req,
    input  logic                target_done,
    output logic                master_grant,
    output logic                target_grant,
    output logic [OE_WIDTH-1:0] pci_ad_out_oe_comb,
    output logic [3:0]          pci_cbe_out_oe_comb,
    output logic                pci_par_out_oe_comb,
    output logic                bus_parked,
    output logic                turnaround_busy
);

    typedef enum logic [2:0] {S_IDLE, S_MDRV, S_TDRV, S_PARK, S_TAR} state_t;

    localparam logic [2:0] TAR_LAST = 3'(TURNAROUND_CYCLES);

    state_t        state_q, state_d;
    logic [2:0]    tar_cnt_q, tar_cnt_d;

    logic          master_start;
    logic          park_cond;

    logic          mgrant_d, tgrant_d, ad_oe_d, cbe_oe_d, parked_d, tar_busy_d;
    logic          mgrant_q, tgrant_q, ad_oe_q, cbe_oe_q, par_oe_q, parked_q, tar_busy_q;

    assign master_start = master_req & pci_gnt_in_prev & pci_bus_idle_prev;

`ifdef PCI_BUS_PARK_EN
    assign park_cond = pci_gnt_in_prev & pci_bus_idle_prev & ~master_req & ~target_req;
`else
    assign park_cond = 1'b0;
`endif

    always_ff @(posedge pci_clk or negedge pci_reset_l) begin
        if (!pci_reset_l) begin
            state_q   <= S_IDLE;
            tar_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            tar_cnt_q <= tar_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tar_cnt_d = tar_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (target_req)        state_d = S_TDRV;
                else if (master_start) state_d = S_MDRV;
                else if (park_cond)    state_d = S_PARK;
            end
            S_MDRV: begin
                if (master_done) begin
                    state_d   = S_TAR;
                    tar_cnt_d = 3'd1;
                end
            end
            S_TDRV: begin
                if (target_done) begin
                    state_d   = S_TAR;
                    tar_cnt_d = 3'd1;
                end
            end
            S_PARK: begin
`ifdef PCI_BUS_PARK_EN
                // A target request must release the parked bus through TAR before it may drive.
                if (target_req || !pci_gnt_in_prev) begin
                    state_d   = S_TAR;
                    tar_cnt_d = 3'd1;
                end else if (master_start) begin
                    state_d   = S_MDRV;
                end
`else
                state_d = S_IDLE;
`endif
            end
            S_TAR: begin
                if (tar_cnt_q >= TAR_LAST) begin
                    state_d   = S_IDLE;
                    tar_cnt_d = '0;
                end else begin
                    tar_cnt_d = tar_cnt_q + 3'd1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                tar_cnt_d = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they switch on the entering edge.
    always_comb begin
        mgrant_d   = (state_d == S_MDRV);
        tgrant_d   = (state_d == S_TDRV);
        ad_oe_d    = (state_d == S_MDRV) || (state_d == S_TDRV) || (state_d == S_PARK);
        cbe_oe_d   = (state_d == S_MDRV) || (state_d == S_PARK);
        parked_d   = (state_d == S_PARK);
        tar_busy_d = (state_d == S_TAR);
    end

    always_ff @(posedge pci_clk or negedge pci_reset_l) begin
        if (!pci_reset_l) begin
            mgrant_q   <= 1'b0;
            tgrant_q   <= 1'b0;
            ad_oe_q    <= 1'b0;
            cbe_oe_q   <= 1'b0;
            par_oe_q   <= 1'b0;
            parked_q   <= 1'b0;
            tar_busy_q <= 1'b0;
        end else begin
            mgrant_q   <= mgrant_d;
            tgrant_q   <= tgrant_d;
            ad_oe_q    <= ad_oe_d;
            cbe_oe_q   <= cbe_oe_d;
            par_oe_q   <= ad_oe_q;
            parked_q   <= parked_d;
            tar_busy_q <= tar_busy_d;
        end
    end

    assign master_grant        = mgrant_q;
    assign target_grant        = tgrant_q;
    assign pci_ad_out_oe_comb  = {OE_WIDTH{ad_oe_q}};
    assign pci_cbe_out_oe_comb = {4{cbe_oe_q}};
    assign pci_par_out_oe_comb = par_oe_q;
    assign bus_parked          = parked_q;
    assign turnaround_busy     = tar_busy_q;

endmodule

// File: tb/tb_pci_ad_drive_sequencer.sv
// Directed self-checking bench for pci_ad_drive_sequencer (default and TURNAROUND_CYCLES=3 instances).
// Park expectations follow whether PCI_BUS_PARK_EN is defined for the build.
module tb_pci_ad_drive_sequencer;

    logic clk = 1'b0;
    logic clk_en = 1'b0;
    logic rst_l = 1'b0;

    logic gnt = 1'b0, idle = 1'b0, mreq = 1'b0, mdone = 1'b0, treq = 1'b0, tdone = 1'b0;
    logic mg, tg, par, pk, busy;
    logic [31:0] ad;
    logic [3:0]  cbe;

    logic gnt3 = 1'b0, idle3 = 1'b0, mreq3 = 1'b0, mdone3 = 1'b0, treq3 = 1'b0, tdone3 = 1'b0;
    logic mg3, tg3, par3, pk3, busy3;
    logic [31:0] ad3;
    logic [3:0]  cbe3;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    pci_ad_drive_sequencer #(.OE_WIDTH(32), .TURNAROUND_CYCLES(1)) dut (
        .pci_clk(clk), .pci_reset_l(rst_l),
        .pci_gnt_in_prev(gnt), .pci_bus_idle_prev(idle),
        .master_req(mreq), .master_done(mdone), .target_req(treq), .target_done(tdone),
        .master_grant(mg), .target_grant(tg),
        .pci_ad_out_oe_comb(ad), .pci_cbe_out_oe_comb(cbe), .pci_par_out_oe_comb(par),
        .bus_parked(pk), .turnaround_busy(busy)
    );

    pci_ad_drive_sequencer #(.OE_WIDTH(32), .TURNAROUND_CYCLES(3)) dut3 (
        .pci_clk(clk), .pci_reset_l(rst_l),
        .pci_gnt_in_prev(gnt3), .pci_bus_idle_prev(idle3),
        .master_req(mreq3), .master_done(mdone3), .target_req(treq3), .target_done(tdone3),
        .master_grant(mg3), .target_grant(tg3),
        .pci_ad_out_oe_comb(ad3), .pci_cbe_out_oe_comb(cbe3), .pci_par_out_oe_comb(par3),
        .bus_parked(pk3), .turnaround_busy(busy3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_mg, input logic e_tg, input logic e_ad,
                           input logic e_cbe, input logic e_par, input logic e_pk, input logic e_busy);
        chk({tag, ".mgrant"}, 64'(mg), 64'(e_mg));
        chk({tag, ".tgrant"}, 64'(tg), 64'(e_tg));
        chk({tag, ".ad_oe"},  64'(ad), 64'({32{e_ad}}));
        chk({tag, ".cbe_oe"}, 64'(cbe), 64'({4{e_cbe}}));
        chk({tag, ".par_oe"}, 64'(par), 64'(e_par));
        chk({tag, ".parked"}, 64'(pk), 64'(e_pk));
        chk({tag, ".busy"},   64'(busy), 64'(e_busy));
    endtask

    initial begin
        int unsigned busy_n;
        int unsigned low_n;
        logic        got;

        clk_en = 1'b1;
        repeat (2) step();
        chk_all("rst_held", 0, 0, 0, 0, 0, 0, 0);
        rst_l = 1'b1;
        step();
        chk_all("rst_rel", 0, 0, 0, 0, 0, 0, 0);

        // Master cycle
        gnt = 1'b1; idle = 1'b1; mreq = 1'b1;
        step();
        chk_all("m_enter", 1, 0, 1, 1, 0, 0, 0);
        mreq = 1'b0;
        step();
        chk_all("m_hold", 1, 0, 1, 1, 1, 0, 0);
        mdone = 1'b1;
        step();
        chk_all("m_done_tar", 0, 0, 0, 0, 1, 0, 1);
        mdone = 1'b0;
        gnt = 1'b0;
        step();
        chk_all("m_idle", 0, 0, 0, 0, 0, 0, 0);

        // Collision: target wins, master waits through turnaround
        gnt = 1'b1; mreq = 1'b1; treq = 1'b1;
        step();
        chk_all("col_tdrv", 0, 1, 1, 0, 0, 0, 0);
        treq = 1'b0; mdone = 1'b1;
        step();
        chk_all("col_mdone_ignored", 0, 1, 1, 0, 1, 0, 0);
        mdone = 1'b0; tdone = 1'b1;
        step();
        chk_all("col_tar", 0, 0, 0, 0, 1, 0, 1);
        tdone = 1'b0;
        step();
        chk_all("col_idle", 0, 0, 0, 0, 0, 0, 0);
        step();
        chk_all("col_mdrv", 1, 0, 1, 1, 0, 0, 0);
        mreq = 1'b0;

        // master_done together with target_req: MDRV -> TAR -> IDLE -> TDRV
        mdone = 1'b1; treq = 1'b1;
        step();
        chk_all("mt_tar", 0, 0, 0, 0, 1, 0, 1);
        mdone = 1'b0;
        step();
        chk_all("mt_idle", 0, 0, 0, 0, 0, 0, 0);
        step();
        chk_all("mt_tdrv", 0, 1, 1, 0, 0, 0, 0);
        treq = 1'b0; tdone = 1'b1;
        step();
        tdone = 1'b0;
        step();
        chk_all("mt_back_idle", 0, 0, 0, 0, 0, 0, 0);

        // Granted idle bus with no requests
        step();
`ifdef PCI_BUS_PARK_EN
        chk_all("park_enter", 0, 0, 1, 1, 0, 1, 0);
        mreq = 1'b1;
        step();
        chk_all("park_to_mdrv", 1, 0, 1, 1, 1, 0, 0);
        mreq = 1'b0; mdone = 1'b1;
        step();
        mdone = 1'b0;
        step();
        step();
        chk_all("park_again", 0, 0, 1, 1, 0, 1, 0);
        gnt = 1'b0;
        step();
        chk_all("park_gnt_lost", 0, 0, 0, 0, 1, 0, 1);
        step();
        chk_all("park_idle", 0, 0, 0, 0, 0, 0, 0);
        gnt = 1'b1;
`else
        step();
        chk_all("nopark", 0, 0, 0, 0, 0, 0, 0);
`endif

        // Async reset mid-drive with the clock stopped
        mreq = 1'b1;
        step();
        mreq = 1'b0;
        step();
        chk_all("pre_rst_mdrv", 1, 0, 1, 1, 1, 0, 0);
        clk_en = 1'b0;
        #2;
        rst_l = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 0, 0, 0);
        gnt = 1'b0; idle = 1'b0;
        #10;
        rst_l = 1'b1;
        #3;
        clk_en = 1'b1;
        step();
        step();
        chk_all("post_rst", 0, 0, 0, 0, 0, 0, 0);

        // TURNAROUND_CYCLES=3 instance: target release followed by waiting master
        treq3 = 1'b1;
        step();
        chk("t3.tgrant", 64'(tg3), 64'd1);
        chk("t3.cbe_oe", 64'(cbe3), 64'd0);
        treq3 = 1'b0; tdone3 = 1'b1;
        step();
        tdone3 = 1'b0; mreq3 = 1'b1; gnt3 = 1'b1; idle3 = 1'b1;
        chk("t3.busy_first", 64'(busy3), 64'd1);
        busy_n = 32'(busy3);
        low_n  = 32'(ad3 == 32'd0);
        got    = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (mg3) begin
                got = 1'b1;
                break;
            end
            busy_n += 32'(busy3);
            low_n  += 32'(ad3 == 32'd0);
        end
        chk("t3.grant_within_bound", 64'(got), 64'd1);
        chk("t3.busy_cycles", 64'(busy_n), 64'd3);
        chk("t3.min_gap", 64'(low_n >= 3), 64'd1);
        chk("t3.ad_oe_on_grant", 64'(ad3), 64'hFFFF_FFFF);
        mreq3 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
